// File: rtl/step_recorder_pkg.sv
// Shared constants, pattern type and FSM encoding for the step recorder and
// the datapath load bus it writes into.
package step_recorder_pkg;

  localparam int unsigned STEPS           = 8;
  localparam int unsigned NUM_INS         = 4;
  localparam int unsigned STEP_W          = $clog2(STEPS);
  localparam int unsigned LD_W            = STEPS;   // load bus width shared with datapath
  localparam int unsigned WR_W            = $clog2(NUM_INS);
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 26;

  typedef logic [LD_W-1:0] pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

endpackage

// File: rtl/step_recorder_if.sv
// Bundle between the sequencer side (bpm tick, pads, datapath patterns) and
// the step recorder.
//   master : sequencer/board side, drives controls and current patterns
//   slave  : step recorder, drives sel/ld_ins and status
interface step_recorder_if;
  import step_recorder_pkg::*;

  logic                step_tick;
  logic [STEP_W-1:0]   timing;
  logic [NUM_INS-1:0]  pad_n;
  logic                arm;
  logic                cancel;
  logic                overdub;
  pattern_t            cur_ins1;
  pattern_t            cur_ins2;
  pattern_t            cur_ins3;
  pattern_t            cur_ins4;
  pattern_t            sel;
  logic [NUM_INS-1:0]  ld_ins;
  logic                recording;
  logic                busy;
  logic                done;

  modport master (
    output step_tick, timing, pad_n, arm, cancel, overdub,
           cur_ins1, cur_ins2, cur_ins3, cur_ins4,
    input  sel, ld_ins, recording, busy, done
  );

  modport slave (
    input  step_tick, timing, pad_n, arm, cancel, overdub,
           cur_ins1, cur_ins2, cur_ins3, cur_ins4,
    output sel, ld_ins, recording, busy, done
  );
endinterface

// File: rtl/step_recorder_pad_sync_edge.sv
// One pad: synchronizer chain, active-low to active-high, registered
// rising-edge detect. o_hit pulses SYNC_STAGES+1 cycles after the pad falls,
// once per press however long it is held.
//   clk, reset : clock, async active-low reset
//   i_pad_n    : raw pad, active-low, asynchronous (SYNC_STAGES >= 2)
//   o_hit      : one-cycle press pulse
module step_recorder_pad_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad_n,
  output logic o_hit
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pressed_d;
  logic                   r_hit;
  logic                   w_pressed;

  assign w_pressed = ~r_sync[SYNC_STAGES-1];
  assign o_hit     = r_hit;

  // Chain resets to the released level so reset never fakes a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= '1;
      r_pressed_d <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_pad_n};
      r_pressed_d <= w_pressed;
      r_hit       <= w_pressed & ~r_pressed_d;
    end
  end

endmodule

// File: rtl/step_recorder.sv
// Live pad recorder: arms, records one 8-step bar of quantized pad hits, then
// writes the four patterns back to the datapath one instrument per cycle.
//   clk, reset : clock, async active-low reset
//   bus        : step tick/timing, pads, arm/cancel/overdub, current patterns
//                in; sel, one-hot ld_ins, recording, busy, done out
module step_recorder
  import step_recorder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  step_recorder_if.slave bus
);

  logic [NUM_INS-1:0]            w_hit;
  logic [NUM_INS-1:0][LD_W-1:0]  w_cur;
  logic [NUM_INS-1:0][LD_W-1:0]  w_hit_mask;
  logic [STEP_W-1:0]             w_idx;
  logic [LD_W-1:0]               w_step_oh;
  logic                          w_round;
  logic                          w_bar_start;

  logic [CNT_W-1:0]              r_elapsed;
  logic [CNT_W-1:0]              r_period;
  state_t                        r_state;
  logic [NUM_INS-1:0][LD_W-1:0]  r_cap;
  logic [WR_W-1:0]               r_wr;
  pattern_t                      r_sel;
  logic [NUM_INS-1:0]            r_ld;
  logic                          r_recording;
  logic                          r_busy;
  logic                          r_done;

  for (genvar g = 0; g < NUM_INS; g++) begin : g_pad
    step_recorder_pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pad (
      .clk     (clk),
      .reset   (reset),
      .i_pad_n (bus.pad_n[g]),
      .o_hit   (w_hit[g])
    );
  end

  assign w_cur = {bus.cur_ins4, bus.cur_ins3, bus.cur_ins2, bus.cur_ins1};

  // Step period measurement, free-running in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elapsed <= '0;
      r_period  <= '0;
    end else if (bus.step_tick) begin
      r_period  <= (r_elapsed == '1) ? '1 : r_elapsed + CNT_W'(1);
      r_elapsed <= '0;
    end else if (r_elapsed != '1) begin
      r_elapsed <= r_elapsed + CNT_W'(1);
    end
  end

  // Round up past the half-step; a tick cycle counts as elapsed=0 and never rounds.
  assign w_round     = !bus.step_tick && (r_period != '0) && (r_elapsed >= (r_period >> 1));
  assign w_idx       = bus.timing + STEP_W'(w_round);   // step 7 + 1 wraps to 0
  assign w_step_oh   = LD_W'(1) << w_idx;
  assign w_bar_start = bus.step_tick && (bus.timing == '0);

  always_comb begin
    w_hit_mask = '0;
    for (int p = 0; p < NUM_INS; p++) begin
      w_hit_mask[p] = w_hit[p] ? w_step_oh : '0;
    end
  end

  // Recorder FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cap       <= '0;
      r_wr        <= '0;
      r_sel       <= '0;
      r_ld        <= '0;
      r_recording <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.arm && !bus.cancel) begin
            r_cap   <= bus.overdub ? w_cur : '0;
            r_state <= ST_ARMED;
            r_busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus.cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_bar_start) begin
            r_cap       <= r_cap | w_hit_mask;
            r_state     <= ST_RECORD;
            r_recording <= 1'b1;
          end
        end
        ST_RECORD: begin
          if (bus.cancel) begin
            r_state     <= ST_IDLE;
            r_recording <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_bar_start) begin
            // Bar closed: hits in this tick cycle belong to the next bar and are dropped.
            r_state     <= ST_WRITE;
            r_recording <= 1'b0;
            r_wr        <= '0;
            r_sel       <= r_cap[0];
            r_ld        <= NUM_INS'(1);
          end else begin
            r_cap <= r_cap | w_hit_mask;
          end
        end
        ST_WRITE: begin
          if (r_wr == WR_W'(NUM_INS - 1)) begin
            r_sel   <= '0;
            r_ld    <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wr  <= r_wr + WR_W'(1);
            r_sel <= r_cap[r_wr + WR_W'(1)];
            r_ld  <= r_ld << 1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.ld_ins    = r_ld;
  assign bus.recording = r_recording;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_step_recorder.sv
module tb_step_recorder;
  import step_recorder_pkg::*;

  localparam int PERIOD = 100;   // clock cycles per step

  logic clk = 1'b0;
  logic reset;

  step_recorder_if bus ();

  step_recorder #(.SYNC_STAGES(2), .CNT_W(26)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pad;
    logic [2:0] step;
    logic [6:0] off;    // cycles after the step's tick cycle when the pad falls
    logic [9:0] hold;
  } press_t;

  typedef struct packed {
    logic             od;
    logic [3:0][7:0]  cur;
    logic [2:0]       np;
    press_t [3:0]     pr;
    logic [3:0][7:0]  exp;
  } vec_t;

  localparam int NV = 5;
  vec_t   vecs [NV];
  press_t press_q [$];

  int         n_chk = 0;
  int         n_err = 0;
  int         ph    = 0;
  logic [2:0] tstep = 3'd0;
  bit         tick_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs for the new cycle are applied #1 after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.step_tick = 1'b0;
    if (tick_en) begin
      ph = (ph >= PERIOD - 1) ? 0 : ph + 1;
      if (ph == 0) begin
        tstep = tstep + 3'd1;
        bus.step_tick = 1'b1;
      end
    end
    bus.timing = tstep;
  endtask

  function automatic press_t mkp(int pad, int step, int off, int hold);
    press_t r;
    r.pad  = 2'(pad);
    r.step = 3'(step);
    r.off  = 7'(off);
    r.hold = 10'(hold);
    return r;
  endfunction

  task automatic set_pads(input int t);
    logic [3:0] p;
    p = '1;
    foreach (press_q[i]) begin
      int st;
      st = int'(press_q[i].step) * PERIOD + int'(press_q[i].off);
      if (t >= st && t < st + int'(press_q[i].hold)) p[press_q[i].pad] = 1'b0;
    end
    bus.pad_n = p;
  endtask

  // Reference: a hit is seen 3 cycles after the fall, at bar-relative cycle
  // det; past the half step (elapsed=d-1 >= 50) it rounds to the next step,
  // with 7 wrapping to 0; detections at or after the closing tick are lost.
  function automatic logic [3:0][7:0] model(input logic od, input logic [3:0][7:0] cur);
    logic [3:0][7:0] r;
    r = od ? cur : '0;
    foreach (press_q[i]) begin
      int det, s, d, b;
      det = int'(press_q[i].step) * PERIOD + int'(press_q[i].off) + 3;
      s = det / PERIOD;
      d = det % PERIOD;
      if (s < 8) begin
        b = (d >= 51) ? (s + 1) % 8 : s;
        r[press_q[i].pad][b] = 1'b1;
      end
    end
    return r;
  endfunction

  // Arm, wait for the bar-start tick, play press_q over the bar.
  task automatic record_bar(input logic od, input logic [3:0][7:0] cur, input int id, output bit ok);
    int w;
    ok = 1'b0;
    bus.overdub  = od;
    bus.cur_ins1 = cur[0];
    bus.cur_ins2 = cur[1];
    bus.cur_ins3 = cur[2];
    bus.cur_ins4 = cur[3];
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    chk($sformatf("v%0d_busy_armed", id), 32'(bus.busy), 32'd1);
    w = 0;
    while (!(bus.step_tick && bus.timing == 3'd0) && w < 2000) begin
      cyc();
      w++;
    end
    if (!(bus.step_tick && bus.timing == 3'd0)) begin
      chk($sformatf("v%0d_bar_start_timeout", id), 32'(bus.step_tick), 32'd1);
      return;
    end
    for (int t = 0; t < 8 * PERIOD; t++) begin
      set_pads(t);
      cyc();
      if (t == 0) chk($sformatf("v%0d_recording", id), 32'(bus.recording), 32'd1);
    end
    bus.pad_n = '1;
    ok = 1'b1;
  endtask

  task automatic check_write(input logic [3:0][7:0] exp, input int id);
    int w;
    w = 0;
    while (bus.ld_ins == '0 && w < 50) begin
      cyc();
      w++;
    end
    if (bus.ld_ins == '0) begin
      chk($sformatf("v%0d_write_timeout", id), 32'(bus.ld_ins), 32'd1);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d_ld%0d", id, k), 32'(bus.ld_ins), 32'd1 << k);
      chk($sformatf("v%0d_sel%0d", id, k), 32'(bus.sel), 32'(exp[k]));
      chk($sformatf("v%0d_done_low%0d", id, k), 32'(bus.done), 32'd0);
      cyc();
    end
    chk($sformatf("v%0d_done", id), 32'(bus.done), 32'd1);
    chk($sformatf("v%0d_ld_after", id), 32'(bus.ld_ins), 32'd0);
    chk($sformatf("v%0d_sel_after", id), 32'(bus.sel), 32'd0);
    cyc();
    chk($sformatf("v%0d_done_pulse", id), 32'(bus.done), 32'd0);
    chk($sformatf("v%0d_busy_idle", id), 32'(bus.busy), 32'd0);
  endtask

  task automatic do_bar(input logic od, input logic [3:0][7:0] cur, input logic [3:0][7:0] exp, input int id);
    bit ok;
    record_bar(od, cur, id, ok);
    if (ok) check_write(exp, id);
  endtask

  initial begin
    bit ok;
    int bad;
    logic [3:0][7:0] cur, exp;

    // Directed vectors with hand-derived expected patterns.
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    vecs[0].np = 3'd4;
    vecs[0].pr[0] = mkp(0, 0, 10, 5);
    vecs[0].pr[1] = mkp(0, 2, 10, 5);
    vecs[0].pr[2] = mkp(0, 4, 10, 5);
    vecs[0].pr[3] = mkp(0, 6, 10, 5);
    vecs[0].exp[0] = 8'h55;
    vecs[1].np = 3'd2;
    vecs[1].pr[0] = mkp(1, 3, 70, 5);   // rounds up to step 4
    vecs[1].pr[1] = mkp(1, 7, 80, 5);   // rounds from 7 to 0
    vecs[1].exp[1] = 8'h11;
    vecs[2].od = 1'b1;
    vecs[2].cur[0] = 8'h3C; vecs[2].cur[1] = 8'h0F;
    vecs[2].cur[2] = 8'hA0; vecs[2].cur[3] = 8'h81;
    vecs[2].np = 3'd1;
    vecs[2].pr[0] = mkp(2, 0, 10, 5);
    vecs[2].exp[0] = 8'h3C; vecs[2].exp[1] = 8'h0F;
    vecs[2].exp[2] = 8'hA1; vecs[2].exp[3] = 8'h81;
    vecs[3].np = 3'd2;
    vecs[3].pr[0] = mkp(3, 1, 47, 5);   // elapsed 49: stays on step 1
    vecs[3].pr[1] = mkp(3, 3, 48, 5);   // elapsed 50: rounds to step 4
    vecs[3].exp[3] = 8'h12;
    vecs[4].np = 3'd3;
    vecs[4].pr[0] = mkp(0, 5, 0, 300);  // falls on the tick into step 5, held 3 steps
    vecs[4].pr[1] = mkp(2, 7, 96, 3);   // seen in the last cycle of the bar, wraps to 0
    vecs[4].pr[2] = mkp(1, 7, 97, 3);   // seen in the closing tick cycle, dropped
    vecs[4].exp[0] = 8'h20;
    vecs[4].exp[2] = 8'h01;

    reset = 1'b0;
    bus.step_tick = 1'b0;
    bus.timing = 3'd0;
    bus.pad_n = '1;
    bus.arm = 1'b0;
    bus.cancel = 1'b0;
    bus.overdub = 1'b0;
    bus.cur_ins1 = '0; bus.cur_ins2 = '0; bus.cur_ins3 = '0; bus.cur_ins4 = '0;
    cyc(); cyc();
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_ld", 32'(bus.ld_ins), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rec", 32'(bus.recording), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < NV; i++) begin
      press_q.delete();
      for (int j = 0; j < int'(vecs[i].np); j++) press_q.push_back(vecs[i].pr[j]);
      do_bar(vecs[i].od, vecs[i].cur, vecs[i].exp, i);
    end

    // cancel beats a simultaneous arm in IDLE
    bus.arm = 1'b1; bus.cancel = 1'b1;
    cyc();
    bus.arm = 1'b0; bus.cancel = 1'b0;
    chk("arm_cancel_busy", 32'(bus.busy), 32'd0);

    // cancel in step 4: no write, no done; a re-arm then records normally
    press_q.delete();
    press_q.push_back(mkp(0, 1, 10, 5));
    bus.overdub = 1'b0;
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    bad = 0;
    while (!(bus.step_tick && bus.timing == 3'd0) && bad < 2000) begin cyc(); bad++; end
    for (int t = 0; t < 4 * PERIOD + 10; t++) begin set_pads(t); cyc(); end
    chk("cancel_pre_rec", 32'(bus.recording), 32'd1);
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
    chk("cancel_rec", 32'(bus.recording), 32'd0);
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    bad = 0;
    for (int t = 0; t < 10 * PERIOD; t++) begin
      cyc();
      if (bus.ld_ins != '0 || bus.done) bad++;
    end
    chk("cancel_no_write", 32'(bad), 32'd0);
    press_q.delete();
    for (int j = 0; j < 4; j++) press_q.push_back(vecs[0].pr[j]);
    do_bar(1'b0, '0, vecs[0].exp, 10);

    // Randomized bars against the reference model
    for (int r = 0; r < 4; r++) begin
      logic od;
      press_q.delete();
      for (int p = 0; p < 4; p++)
        for (int s = 0; s < 8; s++)
          if ($urandom_range(0, 2) == 0)
            press_q.push_back(mkp(p, s, int'($urandom_range(0, 88)), int'($urandom_range(3, 8))));
      od = 1'(($urandom() & 1));
      cur = {$urandom()};
      exp = model(od, cur);
      do_bar(od, cur, exp, 20 + r);
    end

    // Reset in write cycle 1 kills the write-back at once
    press_q.delete();
    for (int j = 0; j < 4; j++) press_q.push_back(vecs[0].pr[j]);
    record_bar(1'b0, '0, 30, ok);
    bad = 0;
    while (bus.ld_ins == '0 && bad < 50) begin cyc(); bad++; end
    cyc();
    chk("rstw_ld_before", 32'(bus.ld_ins), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("rstw_ld", 32'(bus.ld_ins), 32'd0);
    chk("rstw_sel", 32'(bus.sel), 32'd0);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_done", 32'(bus.done), 32'd0);
    bad = 0;
    for (int t = 0; t < 3; t++) begin
      cyc();
      if (bus.ld_ins != '0 || bus.done || bus.busy) bad++;
    end
    tick_en = 1'b0;
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cyc();
      if (bus.ld_ins != '0 || bus.done) bad++;
    end
    chk("rstw_quiet", 32'(bad), 32'd0);

    // First tick after reset starts the bar: long measured period, no rounding
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    for (int t = 0; t < 280; t++) cyc();
    tstep = 3'd7;
    ph = PERIOD - 4;
    tick_en = 1'b1;
    cyc();                   // 3 cycles before the tick
    bus.pad_n[0] = 1'b0;
    cyc(); cyc(); cyc();
    chk("p0_tick", 32'(bus.step_tick), 32'd1);
    for (int t = 0; t < 8 * PERIOD; t++) begin
      bus.pad_n = {2'b11, ~(t >= 77 && t < 82), ~(t < 2)};
      cyc();
    end
    bus.pad_n = '1;
    exp = '0;
    exp[0] = 8'h01;
    exp[1] = 8'h01;
    check_write(exp, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/step_recorder.md
Name: step_recorder

Overview:
Live-input writer for the drum sequencer pattern registers. Captures four pad presses over one 8-step bar, quantizes each hit to the nearest step, then writes the four 8-bit patterns back through the datapath's load interface: sel bus plus one-hot ld strobes, one instrument per cycle. Sits between the board pushbuttons and the datapath, sharing the bpm module's step tick and the 3-bit timing count.

Parameters:
STEPS, 8, steps per bar; sets pattern width and the timing wrap point.
NUM_INS, 4, number of instruments/pads.
SYNC_STAGES, 2, synchronizer flops on each raw pad input.
CNT_W, 26, width of the step-period measurement counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
step_tick  in  1  one-cycle pulse; timing already shows the new step in this cycle
timing  in  3  current step index, 0..7
pad_n  in  4  raw pad buttons, active-low, asynchronous to clk
arm  in  1  level; request to record the next full bar
cancel  in  1  abort the current recording, no writeback
overdub  in  1  sampled at arm: 1 = start from cur_ins*, 0 = start from zero
cur_ins1, cur_ins2, cur_ins3, cur_ins4  in  8 each  current patterns from the datapath
sel  out  8  pattern word presented to the datapath
ld_ins  out  4  one-hot load strobes; bit k loads instrument k+1
recording  out  1  high while in RECORD
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last writeback

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; sel=0, ld_ins=0, recording=0, busy=0, done=0; capture registers, period register and elapsed counter cleared. Reset in the middle of RECORD or WRITE produces no further ld strobes.
- Pad path: SYNC_STAGES flops, then inversion, then rising-edge detect. A hit is recognised SYNC_STAGES+1 cycles after the pad falls. A held pad counts once only.
- Period measurement runs in every state:
  - elapsed increments each cycle and saturates at all-ones.
  - On step_tick: period <= elapsed+1, and elapsed <= 0.
  - While period==0 (no tick seen since reset), rounding is disabled.
- Quantization for a hit detected in a cycle:
  - idx = timing, except idx = (timing+1) mod 8 when period!=0 and elapsed >= period>>1.
  - Round-up from step 7 wraps to bit 0 of the same bar.
  - A hit in a step_tick cycle uses elapsed=0, so it always lands on the new step.
  - Several hits on the same pad and step are ORed into one bit.
- FSM states:
  - IDLE: on arm=1 and cancel=0, load cap[k] = overdub ? cur_ins(k+1) : 0, then go to ARMED.
  - ARMED: on a cycle with step_tick=1 and timing=0, go to RECORD. Hits in that cycle are captured.
  - RECORD: OR each hit into cap[pad][idx]. On the 8th subsequent step_tick (timing=0 again), go to WRITE. Hits in that closing tick cycle are discarded.
  - WRITE: four cycles, k=0..3. In cycle k, sel=cap[k] and ld_ins=1<<k. After cycle 3, sel=0, ld_ins=0, done=1 for one cycle, then go to IDLE.
- cancel=1 in ARMED or RECORD returns to IDLE next cycle with no writes. cancel is ignored during WRITE. cancel wins over a simultaneous arm.
- arm is ignored outside IDLE. arm held through done re-arms from IDLE on the following cycle.
- Outputs are registered. ld_ins is never multi-hot, and sel is stable for the whole cycle its strobe is high.

Decomposition:
- Shared package: STEPS, NUM_INS, the FSM state encoding (IDLE, ARMED, RECORD, WRITE), and the load-bus width shared with the datapath.
- One natural sub-module: pad_sync_edge (synchronizer plus rising-edge detect, per pad, parameterized by SYNC_STAGES). Instantiate it NUM_INS times.

Test Plan:
- Tick every 100 cycles. arm=1, overdub=0. Press pad0 at 10 cycles into each of steps 0, 2, 4 and 6 -> ld_ins=0001 with sel=8'b01010101, then ld_ins=0010/0100/1000 with sel=0 on consecutive cycles, done=1 on the next cycle.
- Press pad1 at 70 cycles into step 3 -> round-up, pattern 8'b00010000. Press pad1 at 80 cycles into step 7 -> wrap, pattern 8'b00000001.
- overdub=1, cur_ins3=8'hA0, one pad2 hit in step 0 -> sel=8'hA1 while ld_ins=0100. Other instruments written back unchanged from cur_ins*.
- cancel pulse mid-RECORD (step 4) -> recording falls next cycle, no ld_ins strobe, no done. A re-arm then records normally.
- Pad falls in the same cycle as a tick that moves timing to 5, and the pad is held for 3 steps -> only bit 5 is set.
- Assert reset during WRITE cycle 1 -> ld_ins=0 immediately and all outputs return to reset values. A single tick with period==0 then a hit -> no rounding applied.
